// File: rtl/button_input_pkg.sv
// Shared FSM state encodings and counter-width helper for the button conditioner.
package button_input_pkg;

    localparam logic [1:0] ST_IDLE         = 2'd0;
    localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] ST_HELD         = 2'd2;
    localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

    typedef enum logic [1:0] {
        IDLE         = ST_IDLE,
        PRESS_WAIT   = ST_PRESS_WAIT,
        HELD         = ST_HELD,
        RELEASE_WAIT = ST_RELEASE_WAIT
    } btn_state_t;

    // Bits needed to hold 0..max_val; never less than one so a zero limit still builds.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/button_channel.sv
// One button: two-flop synchronizer, debounce FSM, hold counter, registered pulses.
// Latency: press/release accepted DEBOUNCE_CYCLES+1 edges after first capture; no backpressure.
module button_channel
    import button_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = 240000,
    parameter int LONG_PRESS_CYCLES = 12000000
) (
    input  logic clock_in,
    input  logic reset_in,
    input  logic button_in,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);

    localparam int DW = cnt_width(DEBOUNCE_CYCLES);
    localparam int HW = cnt_width(LONG_PRESS_CYCLES);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_PRESS_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);
    localparam logic          LONG_EN   = (LONG_PRESS_CYCLES != 0);

    logic            sync1_q;
    logic            sync2_q;
    btn_state_t      state_q;
    logic [DW-1:0]   db_cnt_q;
    logic [HW-1:0]   hold_cnt_q;
    logic            pressed_q;
    logic            press_pulse_q;
    logic            release_pulse_q;
    logic            long_pulse_q;

    // Synchronizer resets to released so a button held through reset must debounce again.
    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= button_in;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            state_q         <= IDLE;
            db_cnt_q        <= '0;
            hold_cnt_q      <= '0;
            pressed_q       <= 1'b0;
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
            long_pulse_q    <= 1'b0;
        end else begin
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
            long_pulse_q    <= 1'b0;

            if (LONG_EN && (state_q == HELD || state_q == RELEASE_WAIT)
                && hold_cnt_q != HOLD_MAX) begin
                hold_cnt_q   <= hold_cnt_q + HW'(1);
                long_pulse_q <= (hold_cnt_q == HOLD_LAST);
            end

            // DB_LAST of zero means a single low/high sample is enough to accept.
            case (state_q)
                IDLE: begin
                    if (!sync2_q) begin
                        if (DB_LAST == '0) begin
                            state_q       <= HELD;
                            pressed_q     <= 1'b1;
                            press_pulse_q <= 1'b1;
                            hold_cnt_q    <= '0;
                        end else begin
                            state_q  <= PRESS_WAIT;
                            db_cnt_q <= DW'(1);
                        end
                    end
                end
                PRESS_WAIT: begin
                    if (sync2_q) begin
                        state_q  <= IDLE;
                        db_cnt_q <= '0;
                    end else if (db_cnt_q == DB_LAST) begin
                        state_q       <= HELD;
                        db_cnt_q      <= '0;
                        pressed_q     <= 1'b1;
                        press_pulse_q <= 1'b1;
                        hold_cnt_q    <= '0;
                    end else begin
                        db_cnt_q <= db_cnt_q + DW'(1);
                    end
                end
                HELD: begin
                    if (sync2_q) begin
                        if (DB_LAST == '0) begin
                            state_q         <= IDLE;
                            pressed_q       <= 1'b0;
                            release_pulse_q <= 1'b1;
                            hold_cnt_q      <= '0;
                        end else begin
                            state_q  <= RELEASE_WAIT;
                            db_cnt_q <= DW'(1);
                        end
                    end
                end
                RELEASE_WAIT: begin
                    if (!sync2_q) begin
                        state_q  <= HELD;
                        db_cnt_q <= '0;
                    end else if (db_cnt_q == DB_LAST) begin
                        state_q         <= IDLE;
                        db_cnt_q        <= '0;
                        pressed_q       <= 1'b0;
                        release_pulse_q <= 1'b1;
                        hold_cnt_q      <= '0;
                    end else begin
                        db_cnt_q <= db_cnt_q + DW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pressed       = pressed_q;
    assign press_pulse   = press_pulse_q;
    assign release_pulse = release_pulse_q;
    assign long_pulse    = long_pulse_q;

endmodule

// File: rtl/button_input.sv
// Button conditioner top: NUM_BUTTONS independent debounced channels, no extra logic.
// Latency: DEBOUNCE_CYCLES+1 edges per accepted change; no backpressure.
module button_input #(
    parameter int NUM_BUTTONS       = 2,
    parameter int DEBOUNCE_CYCLES   = 240000,
    parameter int LONG_PRESS_CYCLES = 12000000
) (
    input  logic                   clock_in,
    input  logic                   reset_in,
    input  logic [NUM_BUTTONS-1:0] button_in,
    output logic [NUM_BUTTONS-1:0] pressed,
    output logic [NUM_BUTTONS-1:0] press_pulse,
    output logic [NUM_BUTTONS-1:0] release_pulse,
    output logic [NUM_BUTTONS-1:0] long_pulse
);

    for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_chan
        button_channel #(
            .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
            .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)
        ) u_chan (
            .clock_in     (clock_in),
            .reset_in     (reset_in),
            .button_in    (button_in[g]),
            .pressed      (pressed[g]),
            .press_pulse  (press_pulse[g]),
            .release_pulse(release_pulse[g]),
            .long_pulse   (long_pulse[g])
        );
    end

endmodule

// File: doc/button_input.md
# button_input

Input-side conditioner for the board's active-low push buttons: the receiving end of the user interface whose output end is the LED driver logic. Each raw pin passes through a two-flop synchronizer and a per-button debounce state machine. The block emits a clean pressed level plus one-cycle press, release and long-press pulses. These feed the start/reset logic of the counter top level, so no raw button is used directly.

## Interface
- NUM_BUTTONS, 2: number of independent button channels.
- DEBOUNCE_CYCLES, 240000: consecutive stable clock_in cycles required to accept a change (20 ms at 12 MHz); must be ≥1.
- LONG_PRESS_CYCLES, 12000000: cycles from accepted press to long_pulse (1 s at 12 MHz); 0 disables long_pulse.
- clock_in  input  1  board clock, all logic on rising edge.
- reset_in  input  1  asynchronous, active-low reset.
- button_in  input  NUM_BUTTONS  raw button pins, active-low (0 = pressed), asynchronous to clock_in.
- pressed  output  NUM_BUTTONS  debounced level, 1 = pressed.
- press_pulse  output  NUM_BUTTONS  one-cycle pulse on accepted press.
- release_pulse  output  NUM_BUTTONS  one-cycle pulse on accepted release.
- long_pulse  output  NUM_BUTTONS  one-cycle pulse, at most once per press.

## Operation
- All channels are identical and fully independent.
- Synchronizer: two flops per bit, both reset to 1 (released). A button held through reset is therefore reported only after a full debounce.
- Per-channel FSM states:
  - IDLE: released, stable.
  - PRESS_WAIT: synchronized sample = 0; debounce counter running.
  - HELD: pressed, stable; hold counter running.
  - RELEASE_WAIT: synchronized sample = 1 while pressed; debounce counter running.
- IDLE→PRESS_WAIT: sample = 0. Debounce counter loads 1.
- PRESS_WAIT:
  - sample returns to 1 → IDLE, counter cleared, no output.
  - counter reaches DEBOUNCE_CYCLES → HELD. Same edge: pressed←1, press_pulse←1, hold counter←0.
- HELD→RELEASE_WAIT: sample = 1. Debounce counter loads 1. pressed stays 1 and the hold counter keeps counting.
- RELEASE_WAIT:
  - sample returns to 0 → HELD, counter cleared.
  - counter reaches DEBOUNCE_CYCLES → IDLE. Same edge: pressed←0, release_pulse←1, hold counter cleared.
- Long press: the hold counter increments every cycle in HELD/RELEASE_WAIT and saturates at LONG_PRESS_CYCLES. long_pulse←1 on the edge it reaches that value, once per press. A press released before that point produces no long_pulse.
- Width rules:
  - Debounce counter is $clog2(DEBOUNCE_CYCLES+1) bits.
  - Hold counter is $clog2(LONG_PRESS_CYCLES+1) bits and never wraps.
- DEBOUNCE_CYCLES = 1: any sample lasting one cycle is accepted.

## Timing
- Reset values: pressed, press_pulse, release_pulse and long_pulse all 0; state IDLE; all counters 0.
- Reset mid-operation immediately forces all reset values. No release_pulse is emitted for a press in progress.
- Let E0 be the edge on which button_in is first captured low. Then:
  - Sync output is 0 after E1.
  - press_pulse and the pressed rise occur at E(1+DEBOUNCE_CYCLES), provided input is stable throughout.
- Release latency, measured from the first edge capturing 1, is identical: DEBOUNCE_CYCLES+1 edges.
- long_pulse comes LONG_PRESS_CYCLES edges after press_pulse.
- Pulses are exactly one cycle wide. press_pulse and release_pulse are never both high on one channel in the same cycle.
- All outputs are registered; there is no combinational path from button_in.

## Structure
- A shared header/package holds the FSM state encodings (2-bit localparams) and the counter-width helper.
- One sub-module, button_channel (single-bit sync + FSM + counters), is instantiated NUM_BUTTONS times by a generate loop. The top level adds no logic.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=10, NUM_BUTTONS=2.
- Clean press: button_in[0] 1→0 captured at E0, held → pressed[0]=1 and press_pulse[0]=1 for one cycle at E5; channel 1 stays 0.
- Bounce: toggle button_in[0] 0/1 every 2 cycles for 20 cycles, then hold 0 → no pulses during bounce; single press_pulse 5 edges after the last falling capture.
- Long press: hold 0 for 30 cycles → press_pulse at E5, one long_pulse at E15, then nothing more until release.
- Short press: press held 8 cycles then released → press_pulse, then release_pulse 5 edges after the release capture; no long_pulse.
- Reset mid-hold: assert reset_in while pressed[1]=1 → all outputs 0 asynchronously, no release_pulse. Deassert with button still low → new press_pulse after 5 edges.
- Simultaneous: both buttons pressed on the same edge → both press_pulse bits asserted in the same cycle.
